shared_ram_arbiter: RTL



---
 rtl/shared_ram_arbiter_pkg.sv | 23 ++
 rtl/shared_ram_arbiter_cs_decode.sv | 13 +
 rtl/shared_ram_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/shared_ram_arbiter_pkg.sv
// Shared types and limits for the System86 shared-RAM arbiter: FSM states,
// requester identifiers, counter width and legal parameter ranges.
package system86_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int CNT_W      = 4;
  localparam int SETUP_MIN  = 0;
  localparam int SETUP_MAX  = 3;
  localparam int ACCESS_MIN = 1;
  localparam int ACCESS_MAX = 15;

endpackage

// File: rtl/shared_ram_arbiter_cs_decode.sv
// 2-line-to-4-line active-low chip-select decoder; all lines high when disabled.
module cs_decode_2to4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_cs_n
);

  always_comb begin
    o_cs_n = 4'hF;
    if (i_en) o_cs_n[i_sel] = 1'b0;
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Round-robin two-requester arbiter and SETUP/ACCESS/RELEASE sequencer for the
// shared RAM bank. Optional nWAITa/nWAITb outputs: define SHARED_RAM_ARB_WAIT_EN.
module shared_ram_arbiter
  import system86_arb_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       nREQa,
  input  logic       nREQb,
  input  logic [1:0] Aa,
  input  logic [1:0] Ab,
  input  logic       nWEa,
  input  logic       nWEb,
  output logic       nGNTa,
  output logic       nGNTb,
  output logic [3:0] nCS,
  output logic       nWE,
  output logic       nACKa,
  output logic       nACKb
`ifdef SHARED_RAM_ARB_WAIT_EN
  ,
  output logic       nWAITa,
  output logic       nWAITb
`endif
);

  if (SETUP_CYCLES < SETUP_MIN || SETUP_CYCLES > SETUP_MAX) begin : g_bad_setup
    $error("shared_ram_arbiter: SETUP_CYCLES out of range 0..3");
  end
  if (ACCESS_CYCLES < ACCESS_MIN || ACCESS_CYCLES > ACCESS_MAX) begin : g_bad_access
    $error("shared_ram_arbiter: ACCESS_CYCLES out of range 1..15");
  end

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t       r_state, w_state_nxt;
  req_id_t          r_owner, w_grant_id;
  req_id_t          r_last;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_addr;
  logic             r_we_n;
  logic             r_armed_a, r_armed_b;
  logic             w_pend_a, w_pend_b;
  logic             w_grant;
  logic             w_rel_a, w_rel_b;
  logic             w_cs_en;

  // An armed flag blocks re-service of a request that is still held after its ACK.
  assign w_pend_a = ~nREQa & r_armed_a;
  assign w_pend_b = ~nREQb & r_armed_b;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_grant_id  = REQ_A;
    case (r_state)
      ST_IDLE: begin
        if (w_pend_a && w_pend_b) begin
          w_grant    = 1'b1;
          w_grant_id = (r_last == REQ_A) ? REQ_B : REQ_A;
        end else if (w_pend_a) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_A;
        end else if (w_pend_b) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_B;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = ACCESS_LD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) w_state_nxt = ST_RELEASE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        // Only the other requester may be handed the bus straight from RELEASE.
        if (r_owner == REQ_A && w_pend_b) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_B;
        end else if (r_owner == REQ_B && w_pend_a) begin
          w_grant    = 1'b1;
          w_grant_id = REQ_A;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_grant) begin
      if (SETUP_CYCLES == 0) begin
        w_state_nxt = ST_ACCESS;
        w_cnt_nxt   = ACCESS_LD;
      end else begin
        w_state_nxt = ST_SETUP;
        w_cnt_nxt   = SETUP_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_owner   <= REQ_A;
      r_last    <= REQ_B;
      r_armed_a <= 1'b1;
      r_armed_b <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_grant) r_owner <= w_grant_id;
      if (r_state == ST_RELEASE) r_last <= r_owner;
      if (w_rel_a)    r_armed_a <= 1'b0;
      else if (nREQa) r_armed_a <= 1'b1;
      if (w_rel_b)    r_armed_b <= 1'b0;
      else if (nREQb) r_armed_b <= 1'b1;
    end
  end

  // Transaction attributes are captured at grant so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_addr <= (w_grant_id == REQ_A) ? Aa   : Ab;
      r_we_n <= (w_grant_id == REQ_A) ? nWEa : nWEb;
    end
  end

  assign w_rel_a = (r_state == ST_RELEASE) && (r_owner == REQ_A);
  assign w_rel_b = (r_state == ST_RELEASE) && (r_owner == REQ_B);
  assign w_cs_en = (r_state == ST_ACCESS);

  cs_decode_2to4 u_cs_decode (
    .i_en   (w_cs_en),
    .i_sel  (r_addr),
    .o_cs_n (nCS)
  );

  assign nGNTa = ~((r_state != ST_IDLE) && (r_owner == REQ_A));
  assign nGNTb = ~((r_state != ST_IDLE) && (r_owner == REQ_B));
  assign nWE   = ~(w_cs_en & ~r_we_n);
  assign nACKa = ~w_rel_a;
  assign nACKb = ~w_rel_b;

`ifdef SHARED_RAM_ARB_WAIT_EN
  assign nWAITa = nREQa | w_rel_a;
  assign nWAITb = nREQb | w_rel_b;
`endif

endmodule
